// File: rtl/mips_pkg.sv
// Shared types for the bus-variant MIPS memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Serialises instruction-fetch and data-port requests onto one Avalon-style
// memory master with waitrequest; read data is registered back to the owner.
//
// state | meaning
// IDLE  | sample i_req / d_req, pick a winner, latch bus registers
// BUS_I | fetch read on the bus, held until waitrequest drops
// BUS_D | data read or write on the bus, held until waitrequest drops
// RESP  | owning port's ready pulse, bus strobes low
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter bit FAIR = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_ready,
  output logic [31:0] i_readdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ready,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  arb_state_t state, state_nxt;
  port_t      last_grant;
  logic       d_req;
  logic       grant_d;

  assign d_req = d_read | d_write;

  // Contention: data always wins unless FAIR, then the port not served last.
  always_comb begin
    grant_d = 1'b0;
    if (d_req && !i_req)
      grant_d = 1'b1;
    else if (d_req && i_req)
      grant_d = FAIR ? (last_grant == INSTR) : 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_req || i_req) state_nxt = grant_d ? BUS_D : BUS_I;
      BUS_I,
      BUS_D:   if (!waitrequest) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= INSTR;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_readdata <= '0;
      d_readdata <= '0;
    end else begin
      state   <= state_nxt;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            if (grant_d) begin
              address    <= d_address;
              write      <= d_write;
              read       <= d_read & ~d_write;
              writedata  <= d_writedata;
              byteenable <= d_byteenable;
            end else begin
              address    <= i_address;
              read       <= 1'b1;
              write      <= 1'b0;
              byteenable <= 4'b1111;
            end
          end
        end
        BUS_I: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            i_readdata <= readdata;
            i_ready    <= 1'b1;
            last_grant <= INSTR;
          end
        end
        BUS_D: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            // Writes leave the data port's read register untouched.
            if (read) d_readdata <= readdata;
            d_ready    <= 1'b1;
            last_grant <= DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench: one arbiter per FAIR setting, random request mixes
// checked against a transaction-level grant/latency model.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req        [2];
  logic [31:0] i_address    [2];
  logic        i_ready      [2];
  logic [31:0] i_readdata   [2];
  logic        d_read       [2];
  logic        d_write      [2];
  logic [31:0] d_address    [2];
  logic [31:0] d_writedata  [2];
  logic [3:0]  d_byteenable [2];
  logic        d_ready      [2];
  logic [31:0] d_readdata   [2];
  logic [31:0] address      [2];
  logic        read         [2];
  logic        write        [2];
  logic [31:0] writedata    [2];
  logic [3:0]  byteenable   [2];
  logic        waitrequest  [2];
  logic [31:0] readdata     [2];

  int n_chk = 0;
  int n_err = 0;

  // Model state: who was served last, and each port's returned-data register.
  bit          last_d [2];
  logic [31:0] i_rd_m [2];
  logic [31:0] d_rd_m [2];

  always #5 clk = ~clk;

  mips_mem_arbiter #(.FAIR(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_address(i_address[0]), .i_ready(i_ready[0]), .i_readdata(i_readdata[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]),
    .d_writedata(d_writedata[0]), .d_byteenable(d_byteenable[0]),
    .d_ready(d_ready[0]), .d_readdata(d_readdata[0]),
    .address(address[0]), .read(read[0]), .write(write[0]), .writedata(writedata[0]),
    .byteenable(byteenable[0]), .waitrequest(waitrequest[0]), .readdata(readdata[0])
  );

  mips_mem_arbiter #(.FAIR(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_address(i_address[1]), .i_ready(i_ready[1]), .i_readdata(i_readdata[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]),
    .d_writedata(d_writedata[1]), .d_byteenable(d_byteenable[1]),
    .d_ready(d_ready[1]), .d_readdata(d_readdata[1]),
    .address(address[1]), .read(read[1]), .write(write[1]), .writedata(writedata[1]),
    .byteenable(byteenable[1]), .waitrequest(waitrequest[1]), .readdata(readdata[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_d[k] = 1'b0;
      i_rd_m[k] = '0;
      d_rd_m[k] = '0;
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0;        i_address[k] = '0;
      d_read[k] = 1'b0;       d_write[k] = 1'b0;
      d_address[k] = '0;      d_writedata[k] = '0;
      d_byteenable[k] = '0;   waitrequest[k] = 1'b1;
      readdata[k] = '0;
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_addr", address[k], 0);
    chk("rst_strobes", {read[k], write[k]}, 0);
    chk("rst_wdata", writedata[k], 0);
    chk("rst_be", byteenable[k], 0);
    chk("rst_ready", {i_ready[k], d_ready[k]}, 0);
    chk("rst_rdata", {i_readdata[k], d_readdata[k]}, 0);
  endtask

  // Called at a negedge with the DUT in IDLE and the winner's request on its
  // inputs. Sampling edge, nwait stalled bus cycles, one completing bus cycle,
  // one ready cycle, then back to IDLE.
  task automatic serve(input int k, input bit gd, input int nwait);
    logic [31:0] ea, ewd, rd;
    logic [3:0]  eb;
    bit          er, ew;
    rd = '0;
    if (gd) begin
      ea = d_address[k]; ew = d_write[k]; er = d_read[k] & ~d_write[k];
      eb = d_byteenable[k]; ewd = d_writedata[k];
    end else begin
      ea = i_address[k]; er = 1'b1; ew = 1'b0; eb = 4'hF; ewd = '0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c <= nwait; c++) begin
      chk("bus_addr", address[k], ea);
      chk("bus_read", read[k], er);
      chk("bus_write", write[k], ew);
      chk("bus_be", byteenable[k], eb);
      if (ew) chk("bus_wdata", writedata[k], ewd);
      chk("ready_early", {i_ready[k], d_ready[k]}, 0);
      waitrequest[k] = (c < nwait);
      rd = $urandom;
      readdata[k] = rd;
      @(posedge clk);
      @(negedge clk);
    end
    if (gd && er) d_rd_m[k] = rd;
    if (!gd) i_rd_m[k] = rd;
    last_d[k] = gd;
    chk("ready_pulse", {i_ready[k], d_ready[k]}, gd ? 2'b01 : 2'b10);
    chk("i_readdata", i_readdata[k], i_rd_m[k]);
    chk("d_readdata", d_readdata[k], d_rd_m[k]);
    chk("resp_strobes", {read[k], write[k]}, 0);
    if (gd) begin
      d_read[k] = 1'b0; d_write[k] = 1'b0;
    end else begin
      i_req[k] = 1'b0;
    end
    waitrequest[k] = $urandom_range(0, 1);
    readdata[k] = $urandom;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after", {i_ready[k], d_ready[k]}, 0);
    chk("idle_strobes", {read[k], write[k]}, 0);
  endtask

  // dmode: 0 none, 1 read, 2 write, 3 read+write
  task automatic round(input int k, input bit ireq, input int dmode,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dbe,
                       input int w1, input int w2);
    bit dreq, gd;
    i_req[k] = ireq; i_address[k] = ia;
    d_read[k] = dmode[0]; d_write[k] = dmode[1];
    d_address[k] = da; d_writedata[k] = dwd; d_byteenable[k] = dbe;
    dreq = (dmode != 0);
    if (ireq && dreq) gd = (k == 0) ? 1'b1 : !last_d[k];
    else gd = dreq;
    serve(k, gd, w1);
    if (ireq && dreq) serve(k, !gd, w2);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) chk_reset_vals(k);
    reset = 1'b0;
    @(negedge clk);

    // Lone fetch, then a data write stalled for three cycles.
    round(0, 1'b1, 0, 32'hBFC0_0000, '0, '0, '0, 0, 0);
    chk("fetch_word", i_readdata[0], i_rd_m[0]);
    round(0, 1'b0, 2, '0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 0);

    // Contention: FAIR=0 data always first; FAIR=1 alternates from reset.
    for (int r = 0; r < 3; r++) begin
      round(0, 1'b1, 1, $urandom, $urandom, $urandom, 4'hF, r, 1);
      chk("fair0_last", last_d[0], 0);
    end
    for (int r = 0; r < 2; r++)
      round(1, 1'b1, 2, $urandom, $urandom, $urandom, 4'hC, 0, r);
    round(1, 1'b0, 3, '0, 32'h0000_2000, 32'h1234_5678, 4'hF, 1, 0);

    // Random mixes on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 40; r++) begin
        bit ir;
        int dm;
        ir = $urandom_range(0, 1);
        dm = $urandom_range(0, 3);
        if (!ir && dm == 0) ir = 1'b1;
        round(k, ir, dm, $urandom, $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    // Reset mid-wait on a data write: strobe must drop without a clock edge.
    i_req[0] = 1'b0;
    d_write[0] = 1'b1; d_address[0] = 32'h0000_1000;
    d_writedata[0] = 32'hDEAD_BEEF; d_byteenable[0] = 4'b0011;
    waitrequest[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_write", write[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("async_write_drop", write[0], 0);
    chk("async_ready", d_ready[0], 0);
    model_reset();
    clear_inputs();
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ready", {i_ready[0], d_ready[0]}, 0);
    end
    chk_reset_vals(0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", d_ready[0], 0);
    round(0, 1'b1, 0, 32'hBFC0_0004, '0, '0, '0, 1, 0);
    round(1, 1'b1, 1, $urandom, $urandom, $urandom, 4'hF, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Arbitrates one shared memory bus between the CPU's instruction-fetch port and data port, for the bus (von Neumann) CPU variant. Each port issues single-word requests with a ready handshake; the arbiter serialises them onto a single Avalon-style master interface with `waitrequest`. It returns read data to the owning port. It sits between the CPU control FSM and the external memory.

## Interface
Parameters:
- `FAIR`, default 0. When 0, data wins simultaneous requests. When 1, simultaneous requests alternate starting with data.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_req` in 1: instruction fetch request; held until `i_ready`.
- `i_address` in 32: fetch byte address; stable while `i_req` is high.
- `i_ready` out 1: one-cycle pulse; fetch complete.
- `i_readdata` out 32: fetched word; valid while `i_ready` is high.
- `d_read` in 1: data read request.
- `d_write` in 1: data write request.
- `d_address` in 32: data byte address.
- `d_writedata` in 32: write data.
- `d_byteenable` in 4: byte lanes for the data access.
- `d_ready` out 1: one-cycle pulse; data access complete.
- `d_readdata` out 32: read data; valid while `d_ready` is high.
- `address` out 32: bus address.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `writedata` out 32: bus write data.
- `byteenable` out 4: bus byte enables.
- `waitrequest` in 1: bus stall.
- `readdata` in 32: bus read data.

## Operation
- FSM states are IDLE, BUS_I, BUS_D and RESP.
- IDLE:
  - Samples `i_req` and `d_req` = `d_read|d_write`.
  - If only one is high, that port is granted.
  - If both are high, the grant follows `FAIR`.
    - `FAIR`=0: data wins.
    - `FAIR`=1: the port not in `last_grant` wins. `last_grant` resets to INSTR.
  - On grant, the arbiter latches address, direction, writedata and byteenable into bus registers, then moves to BUS_I or BUS_D.
- BUS_I:
  - `read`=1, `write`=0, `byteenable`=4'b1111, `address`=latched `i_address`.
- BUS_D:
  - `write`=latched `d_write`, `read`=latched `d_read & ~d_write`. If both strobes are high, the write wins and the read is dropped.
- Completion:
  - In BUS_x, the first cycle with `waitrequest`=0 completes the transfer.
  - `readdata` is captured into the port's readdata register on that edge. Writes capture nothing.
  - `last_grant` is updated, and the FSM moves to RESP.
- RESP:
  - The owning port's ready output is high for exactly one cycle. The other port's ready output stays low.
  - Bus strobes are 0.
  - The FSM then returns to IDLE.
- Requester rule: deassert the request, or present a new one, on the edge that ends its ready cycle. Requests are only sampled in IDLE, so a request held too long re-issues the access.
- Requests arriving during BUS_x or RESP wait; the arbiter never preempts a transfer in progress.
- All addresses pass through unmodified as byte addresses. Alignment is the requester's responsibility.

## Timing
- Reset values:
  - State is IDLE.
  - `read`, `write`, `i_ready` and `d_ready` are 0.
  - `address`, `writedata`, `i_readdata` and `d_readdata` are 0.
  - `byteenable` is 0.
  - `last_grant` is INSTR.
- Reset is asynchronous. Asserting it mid-transfer drops the strobes immediately, and no ready pulse is issued for the aborted access.
- Minimum latency:
  - Request sampled in IDLE at edge n.
  - Bus strobe high during cycle n+1.
  - With `waitrequest` low, ready is high during cycle n+2.
  - The next IDLE sample is at edge n+3.
- Each wait-state cycle adds one cycle of latency. Bus signals stay stable while `waitrequest`=1.
- Bus outputs are registered; there is no combinational path from any request input to a bus output.
- The one combinational input→output path is none; `readdata` is registered before it is returned.

## Structure
- Shared package `mips_pkg` holds:
  - `arb_state_t`: 2-bit enum IDLE/BUS_I/BUS_D/RESP.
  - `port_t`: INSTR/DATA.
- No sub-module; a single always_ff plus next-state logic, roughly 150–200 lines.

## Test plan
- Lone fetch: `i_req`, `i_address`=0xBFC00000, `readdata`=0x24020005, no wait → `read`=1 with that address for one cycle; `i_ready`=1 with `i_readdata`=0x24020005 two cycles after the request.
- Data write with wait states: `d_write`, address 0x1000, data 0xDEADBEEF, byteenable 4'b0011, `waitrequest` high for 3 cycles → `write` held stable for 4 cycles; `d_ready` on the following cycle; `i_ready` stays 0.
- Simultaneous requests, `FAIR`=0, repeated three times → data is granted every time; the fetch is served only in the IDLE where `d_req` is low.
- Simultaneous requests, `FAIR`=1, repeated → grants alternate D, I, D, I starting from reset.
- Reset asserted in BUS_D mid-wait → `write` falls without waiting for a clock edge; no `d_ready`; after release, a new fetch completes normally.
- `d_read` and `d_write` both high → bus sees `write`=1, `read`=0.
